// File: rtl/mult8b_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one add step per clock.
// The addend mux and ripple adder are built from NAND gates.
module mult8b_seq #(
   parameter bit PULSE_DONE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mcand, hi, lo;
   logic [3:0]  count;
   logic [7:0]  addend, sum;
   logic [8:0]  c;
   logic        nsel;
   logic        accept, step, finish;

   assign nsel = ~(lo[0] & lo[0]);
   assign c[0] = 1'b0;

   // Per bit: 2:1 NAND mux (mcand vs zero) feeding a 9-NAND full adder.
   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_bit
         logic m1, m0;
         logic t1, t2, t3, x, t4, t5, t6;
         assign m1        = ~(lo[0] & mcand[i]);
         assign m0        = ~(nsel & 1'b0);
         assign addend[i] = ~(m1 & m0);
         assign t1        = ~(hi[i] & addend[i]);
         assign t2        = ~(hi[i] & t1);
         assign t3        = ~(addend[i] & t1);
         assign x         = ~(t2 & t3);
         assign t4        = ~(x & c[i]);
         assign t5        = ~(x & t4);
         assign t6        = ~(c[i] & t4);
         assign sum[i]    = ~(t5 & t6);
         assign c[i+1]    = ~(t1 & t4);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == 4'd7) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= 8'h00;
         hi      <= 8'h00;
         lo      <= 8'h00;
         count   <= 4'd0;
         product <= 16'h0000;
         done    <= 1'b0;
      end else begin
         if (accept) begin
            mcand <= a;
            lo    <= b;
            hi    <= 8'h00;
            count <= 4'd0;
         end else if (step) begin
            // 9-bit sum shifts right into the hi/lo pair
            hi    <= {c[8], sum[7:1]};
            lo    <= {sum[0], lo[7:1]};
            count <= count + 4'd1;
         end
         if (finish)
            product <= {c[8], sum, lo[7:1]};
         if (finish)
            done <= 1'b1;
         else if (PULSE_DONE || accept)
            done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult8b_seq.sv
// Scoreboard bench for mult8b_seq: pulse-done instance plus a held-done instance.
module tb_mult8b_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start0;
   logic [7:0]  a, b, a0, b0;
   logic        busy, done, busy0, done0;
   logic [15:0] product, product0;

   int passed = 0;
   int total  = 0;
   logic [15:0] q1[$];
   logic [15:0] q0[$];
   logic [15:0] e1, e0;
   logic        done0_q;

   always #5 clk = ~clk;

   mult8b_seq #(.PULSE_DONE(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product));

   mult8b_seq #(.PULSE_DONE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .product(product0));

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // counts edges until busy drops; a timeout shows up as a wrong count
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin tick(); n++; end
   endtask

   task automatic wait_idle0(output int n);
      n = 0;
      while (busy0 && n < 40) begin tick(); n++; end
   endtask

   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      int n;
      start = 1'b1; a = x; b = y;
      q1.push_back(exp);
      tick();
      start = 1'b0;
      wait_idle(n);
      check("op_latency", 16'(n), 16'd8);
   endtask

   // pulse-done monitor: every done cycle must match a pending expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q1.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got done=1 with product %h, expected no done", product);
         end else begin
            e1 = q1.pop_front();
            check("product", product, e1);
         end
      end
   end

   // held-done monitor: compares on the rising edge of done
   always @(negedge clk) begin
      if (rst) done0_q <= 1'b0;
      else begin
         if (done0 && !done0_q) begin
            if (q0.size() == 0) begin
               total++;
               $display("FAIL unexpected_done0: got done=1 with product %h, expected no done", product0);
            end else begin
               e0 = q0.pop_front();
               check("product0", product0, e0);
            end
         end
         done0_q <= done0;
      end
   end

   initial begin
      int n;
      logic seen;
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
      start0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_product", product, 16'h0000);
      rst = 1'b0;
      tick();

      // 1: 0F*0F, busy for 8 edges, one-cycle done
      start = 1'b1; a = 8'h0F; b = 8'h0F;
      q1.push_back(16'h00E1);
      tick();
      start = 1'b0;
      check("t1_busy", 16'(busy), 16'd1);
      wait_idle(n);
      check("t1_busy_cycles", 16'(n), 16'd8);
      check("t1_done", 16'(done), 16'd1);
      check("t1_product", product, 16'h00E1);
      tick();
      check("t1_done_pulse", 16'(done), 16'd0);

      // 2: zero product, then max carry path
      run_op(8'h00, 8'hA5, 16'h0000);
      run_op(8'hFF, 8'hFF, 16'hFE01);
      tick();

      // 3: start during RUN ignored; product holds old value meanwhile
      start = 1'b1; a = 8'h12; b = 8'h34;
      q1.push_back(16'h03A8);
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      tick();
      start = 1'b0; a = 8'h00; b = 8'h00;
      check("t3_busy", 16'(busy), 16'd1);
      check("t3_product_hold", product, 16'hFE01);
      wait_idle(n);
      check("t3_cycles", 16'(n), 16'd5);
      tick();

      // 4: reset mid-operation aborts, no done afterwards
      start = 1'b1; a = 8'h80; b = 8'h02;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      check("t4_busy", 16'(busy), 16'd0);
      check("t4_done", 16'(done), 16'd0);
      check("t4_product", product, 16'h0000);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("t4_no_done", 16'(seen), 16'd0);

      // 5: start held high, back-to-back operations
      start = 1'b1; a = 8'h03; b = 8'h05;
      q1.push_back(16'h000F);
      q1.push_back(16'h003F);
      tick();
      a = 8'h07; b = 8'h09;
      wait_idle(n);
      check("t5_first_cycles", 16'(n), 16'd8);
      check("t5_first_product", product, 16'h000F);
      tick();
      start = 1'b0;
      check("t5_reaccept_busy", 16'(busy), 16'd1);
      check("t5_hold_old", product, 16'h000F);
      wait_idle(n);
      check("t5_second_cycles", 16'(n), 16'd8);
      tick();

      // 6: held done on the PULSE_DONE=0 instance
      start0 = 1'b1; a0 = 8'h10; b0 = 8'h10;
      q0.push_back(16'h0100);
      tick();
      start0 = 1'b0;
      wait_idle0(n);
      check("t6_cycles", 16'(n), 16'd8);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t6_done_held", 16'(done0), 16'd1);
         check("t6_product_held", product0, 16'h0100);
      end
      start0 = 1'b1; a0 = 8'h02; b0 = 8'h03;
      q0.push_back(16'h0006);
      tick();
      start0 = 1'b0;
      check("t6_done_cleared", 16'(done0), 16'd0);
      wait_idle0(n);
      check("t6_done_again", 16'(done0), 16'd1);
      repeat (2) tick();

      check("sb_empty", 16'(q1.size()), 16'd0);
      check("sb0_empty", 16'(q0.size()), 16'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
